// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and constants for the serial-to-parallel receiver.
// FSM state encoding and the default frame width live here.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } s2p_state_t;

    localparam int S2P_DEFAULT_WIDTH = 8;

    // Bit-counter width able to index WIDTH data bits (WIDTH >= 2).
    function automatic int s2p_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: WIDTH-bit serial-in shift register.
// MSB_FIRST=1 shifts left (first bit ends in the MSB), else shifts right.
module s2p_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             CLR,
    input  logic             SHIFT_EN,
    input  logic             BIT_IN,
    output logic [WIDTH-1:0] DATA_OUT
);

    logic [WIDTH-1:0] data_q;

    // Clear at frame start, otherwise shift one bit in per enable.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
        end else if (CLR) begin
            data_q <= '0;
        end else if (SHIFT_EN) begin
            if (MSB_FIRST) begin
                data_q <= {data_q[WIDTH-2:0], BIT_IN};
            end else begin
                data_q <= {BIT_IN, data_q[WIDTH-1:1]};
            end
        end
    end

    assign DATA_OUT = data_q;

endmodule

// File: rtl/s2p_deserializer.sv
// s2p_deserializer: start / WIDTH data / [even parity] / stop receiver
// with a one-word held output. Define S2P_PARITY_EN to add the parity bit.
module s2p_deserializer
    import s2p_pkg::*;
#(
    parameter int WIDTH     = S2P_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             SER_IN,
    input  logic             SER_VALID,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    input  logic             PAR_READY,
    output logic             BUSY,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic             PARITY_ERR
);

    localparam int CNT_W = s2p_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    s2p_state_t       state_q;
    s2p_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sh_data;
    logic             sh_clr;
    logic             sh_en;
    logic             done;
    logic             ferr_set;
    logic             par_bad;
    logic [WIDTH-1:0] out_q;
    logic             vld_q;
    logic             ovr_q;
    logic             ferr_q;

`ifdef S2P_PARITY_EN
    logic             par_chk;
    logic             perr_set;
    logic             par_bad_q;
    logic             perr_q;
`endif

    s2p_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .CLK_IN   (CLK_IN),
        .RST      (RST),
        .CLR      (sh_clr),
        .SHIFT_EN (sh_en),
        .BIT_IN   (SER_IN),
        .DATA_OUT (sh_data)
    );

    // State register; only moves on qualified bit cycles.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-bit control strobes.
    always_comb begin
        state_d  = state_q;
        sh_clr   = 1'b0;
        sh_en    = 1'b0;
        done     = 1'b0;
        ferr_set = 1'b0;
`ifdef S2P_PARITY_EN
        par_chk  = 1'b0;
        perr_set = 1'b0;
`endif
        if (SER_VALID) begin
            case (state_q)
                IDLE: begin
                    if (!SER_IN) begin
                        state_d = DATA;
                        sh_clr  = 1'b1;
                    end
                end
                DATA: begin
                    sh_en = 1'b1;
                    if (cnt_q == LAST) begin
`ifdef S2P_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef S2P_PARITY_EN
                    par_chk = 1'b1;
                    state_d = STOP;
`else
                    state_d = IDLE;
`endif
                end
                STOP: begin
                    state_d  = IDLE;
                    done     = SER_IN && !par_bad;
                    ferr_set = !SER_IN;
`ifdef S2P_PARITY_EN
                    perr_set = par_bad;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Data bit counter, restarted by each start bit.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (sh_clr) begin
            cnt_q <= '0;
        end else if (sh_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef S2P_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            par_bad_q <= 1'b0;
        end else if (par_chk) begin
            par_bad_q <= (^sh_data) ^ SER_IN;
        end
    end

    assign par_bad = par_bad_q;

    // Parity error pulse, aligned with the stop-bit outcome.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_set;
        end
    end

    assign PARITY_ERR = perr_q;
`else
    assign par_bad    = 1'b0;
    assign PARITY_ERR = 1'b0;
`endif

    // Output buffer: load on completion unless a stalled word blocks it.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            out_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done) begin
                if (vld_q && !PAR_READY) begin
                    ovr_q <= 1'b1;
                end else begin
                    out_q <= sh_data;
                    vld_q <= 1'b1;
                end
            end else if (vld_q && PAR_READY) begin
                vld_q <= 1'b0;
            end
        end
    end

    // Framing error pulse for a low stop bit.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_set;
        end
    end

    assign PAR_OUT   = out_q;
    assign PAR_VALID = vld_q;
    assign OVERRUN   = ovr_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_s2p_deserializer.sv
// tb_s2p_deserializer: frame-level reference model with a scoreboard
// of expected words and error pulses, checked by a separate monitor.
module tb_s2p_deserializer;

    localparam int W  = 8;
    localparam bit MF = 1'b1;

    logic         CLK_IN    = 1'b0;
    logic         RST       = 1'b0;
    logic         SER_IN    = 1'b1;
    logic         SER_VALID = 1'b0;
    logic         PAR_READY = 1'b1;
    logic [W-1:0] PAR_OUT;
    logic         PAR_VALID;
    logic         BUSY;
    logic         FRAME_ERR;
    logic         OVERRUN;
    logic         PARITY_ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rdy_pct = 100;
    bit m_valid = 1'b0;
    bit mon_en  = 1'b0;

    logic [W-1:0] exp_words[$];
    int           exp_ferr[$];
    int           exp_ovr[$];
    int           exp_perr[$];

    logic [W-1:0] prev_out;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;

    s2p_deserializer #(
        .WIDTH     (W),
        .MSB_FIRST (MF)
    ) dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .SER_IN     (SER_IN),
        .SER_VALID  (SER_VALID),
        .PAR_OUT    (PAR_OUT),
        .PAR_VALID  (PAR_VALID),
        .PAR_READY  (PAR_READY),
        .BUSY       (BUSY),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .PARITY_ERR (PARITY_ERR)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    function automatic bit get_rdy();
        return $urandom_range(0, 99) < rdy_pct;
    endfunction

    // ev: 0 none, 1 good frame, 2 stop error, 3 parity error, 4 both
    task automatic step(input bit sv, input bit si, input bit rdy,
                        input int ev, input logic [W-1:0] wd);
        SER_VALID = sv;
        SER_IN    = si;
        PAR_READY = rdy;
        @(posedge CLK_IN);
        cyc++;
        if (ev == 1) begin
            if (m_valid && !rdy) begin
                exp_ovr.push_back(cyc);
            end else begin
                exp_words.push_back(wd);
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (ev == 2 || ev == 4) exp_ferr.push_back(cyc);
        if (ev == 3 || ev == 4) exp_perr.push_back(cyc);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b1, get_rdy(), 0, '0);
            chk("busy_idle", BUSY, 0);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit stop,
                              input bit pflip, input int gap,
                              input int lr);
        bit bits[$];
        bit pe;
        bit rdy;
        int ev;
        int last;
        pe = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            bits.push_back(MF ? d[W-1-i] : d[i]);
        end
`ifdef S2P_PARITY_EN
        bits.push_back((^d) ^ pflip);
        pe = pflip;
`endif
        bits.push_back(stop);
        last = bits.size() - 1;
        for (int i = 0; i <= last; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                step(1'b0, 1'($urandom_range(0, 1)), get_rdy(), 0, '0);
                chk("busy_gap", BUSY, (i > 0) ? 1 : 0);
            end
            ev  = 0;
            rdy = get_rdy();
            if (i == last) begin
                if (stop && !pe) ev = 1;
                else if (!stop && pe) ev = 4;
                else if (!stop) ev = 2;
                else ev = 3;
                if (lr >= 0) rdy = lr[0];
            end
            step(1'b1, bits[i], rdy, ev, d);
            chk("busy_bit", BUSY, (i < last) ? 1 : 0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge CLK_IN) begin
        if (mon_en) begin
            if (PAR_VALID && PAR_READY) begin
                if (exp_words.size() == 0) miss("word_extra");
                else chk("word", PAR_OUT, exp_words.pop_front());
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", PAR_VALID, 1);
                chk("stall_data", PAR_OUT, prev_out);
            end
            if (FRAME_ERR) begin
                if (exp_ferr.size() == 0) miss("frame_err_extra");
                else chk("frame_err_cycle", cyc, exp_ferr.pop_front());
            end else if (exp_ferr.size() != 0 && exp_ferr[0] <= cyc) begin
                chk("frame_err_pulse", FRAME_ERR, 1);
                void'(exp_ferr.pop_front());
            end
            if (OVERRUN) begin
                if (exp_ovr.size() == 0) miss("overrun_extra");
                else chk("overrun_cycle", cyc, exp_ovr.pop_front());
            end else if (exp_ovr.size() != 0 && exp_ovr[0] <= cyc) begin
                chk("overrun_pulse", OVERRUN, 1);
                void'(exp_ovr.pop_front());
            end
            if (PARITY_ERR) begin
                if (exp_perr.size() == 0) miss("parity_err_extra");
                else chk("parity_err_cycle", cyc, exp_perr.pop_front());
            end else if (exp_perr.size() != 0 && exp_perr[0] <= cyc) begin
                chk("parity_err_pulse", PARITY_ERR, 1);
                void'(exp_perr.pop_front());
            end
        end
        prev_valid <= PAR_VALID;
        prev_ready <= PAR_READY;
        prev_out   <= PAR_OUT;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_par_out", PAR_OUT, 0);
        chk("rst_par_valid", PAR_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        chk("rst_overrun", OVERRUN, 0);
        chk("rst_parity_err", PARITY_ERR, 0);
        @(posedge CLK_IN);
        #1;
        RST    = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Basic frame, latency and one-cycle valid.
        rdy_pct = 100;
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1);
        chk("lat_valid", PAR_VALID, 1);
        chk("lat_data", PAR_OUT, 8'hA5);
        idle(1);
        chk("valid_one_cycle", PAR_VALID, 0);

        // Same frame with gaps.
        send_frame(8'hA5, 1'b1, 1'b0, 50, 1);
        chk("gap_data", PAR_OUT, 8'hA5);
        idle(1);

        // Stop-bit error then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1);
        chk("ferr_no_valid", PAR_VALID, 0);
        idle(1);
        chk("ferr_no_valid2", PAR_VALID, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1);
        chk("after_ferr", PAR_OUT, 8'h5A);
        idle(2);

        // Overrun while stalled, then completion on a handshake edge.
        rdy_pct = 0;
        send_frame(8'h11, 1'b1, 1'b0, 0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 0, -1);
        chk("ovr_held", PAR_OUT, 8'h11);
        rdy_pct = 100;
        idle(2);
        rdy_pct = 0;
        send_frame(8'h11, 1'b1, 1'b0, 0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1);
        chk("hs_load_data", PAR_OUT, 8'h22);
        chk("hs_load_valid", PAR_VALID, 1);
        rdy_pct = 100;
        idle(2);

        // Reset after four data bits.
        step(1'b1, 1'b0, 1'b1, 0, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 0, '0);
        #2;
        RST = 1'b0;
        m_valid = 1'b0;
        #1;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_valid", PAR_VALID, 0);
        chk("mid_rst_out", PAR_OUT, 0);
        step(1'b0, 1'b1, 1'b1, 0, '0);
        step(1'b0, 1'b1, 1'b1, 0, '0);
        RST = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, 0, 1);
        chk("post_rst_data", PAR_OUT, 8'hC3);
        idle(1);

`ifdef S2P_PARITY_EN
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1);
        chk("par_ok_valid", PAR_VALID, 1);
        idle(1);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 1);
        chk("par_bad_valid", PAR_VALID, 0);
        idle(1);
`endif

        // Randomized traffic.
        for (int f = 0; f < 200; f++) begin
            rdy_pct = $urandom_range(30, 100);
            send_frame(W'($urandom), $urandom_range(0, 9) != 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 40), -1);
            idle($urandom_range(0, 2));
        end

        rdy_pct = 100;
        idle(4);
        chk("end_valid", PAR_VALID, 0);
        chk("words_left", exp_words.size(), 0);
        chk("ferr_left", exp_ferr.size(), 0);
        chk("ovr_left", exp_ovr.size(), 0);
        chk("perr_left", exp_perr.size(), 0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
